imem_loadable: RTL

Parametrised successor to the single-cycle instruction memory: a synchronous, word-addressed instruction store with a registered fetch port and a streaming program-load port. It sits between the PC/fetch stage and the test or boot infrastructure. The core can fetch one instruction per cycle, and a host can reload the program without re-elaborating the design. Misaligned and out-of-range fetches return a NOP and raise a fault flag instead of aliasing.

---
 rtl/imem_loadable.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/imem_loadable.sv
// Word-addressed instruction store with a registered single-cycle fetch port
// and a streaming program-load port; faulting fetches return NOP_INSTR.
module imem_loadable #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 1024,
    parameter int unsigned     ADDR_W    = $clog2(DEPTH),
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_i,
    input  logic [XLEN-1:0]   fetch_addr_i,
    output logic              fetch_ready_o,
    output logic              fetch_valid_o,
    output logic [XLEN-1:0]   fetch_data_o,
    output logic              fetch_fault_o,
    input  logic              load_start_i,
    input  logic [XLEN-1:0]   load_base_i,
    input  logic              load_valid_i,
    input  logic [XLEN-1:0]   load_data_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   load_count_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Any address bit above the word-index field makes the fetch out of range.
    localparam logic [XLEN-1:0]   HI_MASK   = ~((XLEN'(1) << (ADDR_W + 2)) - XLEN'(1));
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    logic [XLEN-1:0]   mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_fault_q, fetch_fault_d;
    logic [XLEN-1:0]   fetch_data_q, fetch_data_d;
    logic              load_done_q, load_done_d;

    logic              fetch_accept_s;
    logic              load_beat_s;
    logic              addr_fault_s;
    logic [ADDR_W-1:0] fetch_idx_s;
    logic              load_base_unused_s;

    assign fetch_idx_s        = fetch_addr_i[ADDR_W+1:2];
    assign addr_fault_s       = (fetch_addr_i[1:0] != 2'b00) || ((fetch_addr_i & HI_MASK) != '0);
    assign load_base_unused_s = ^load_base_i;

    assign fetch_ready_o = (state_q == ST_RUN);
    assign load_ready_o  = (state_q == ST_LOAD);
    assign fetch_valid_o = fetch_valid_q;
    assign fetch_fault_o = fetch_fault_q;
    assign fetch_data_o  = fetch_data_q;
    assign load_done_o   = load_done_q;
    assign load_count_o  = count_q;

    // Next-state, load pointer/count and fetch response computation.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        count_d        = count_q;
        fetch_valid_d  = 1'b0;
        fetch_fault_d  = fetch_fault_q;
        fetch_data_d   = fetch_data_q;
        load_done_d    = 1'b0;
        fetch_accept_s = 1'b0;
        load_beat_s    = 1'b0;

        case (state_q)
            ST_RUN: begin
                fetch_accept_s = fetch_req_i;
                if (load_start_i) begin
                    state_d = ST_LOAD;
                    ptr_d   = load_base_i[ADDR_W+1:2];
                    count_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                load_beat_s = load_valid_i;
                if (load_valid_i) begin
                    ptr_d = ptr_q + 1'b1;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        count_d = count_q;
                    end
                    if (load_last_i) begin
                        state_d     = ST_DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Loads and fetches never overlap, so the read needs no write bypass.
        if (fetch_accept_s) begin
            fetch_valid_d = 1'b1;
            fetch_fault_d = addr_fault_s;
            if (addr_fault_s) begin
                fetch_data_d = NOP_INSTR;
            end else begin
                fetch_data_d = mem_q[fetch_idx_s];
            end
        end else begin
            fetch_valid_d = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            ptr_q         <= '0;
            count_q       <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_data_q  <= NOP_INSTR;
            load_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            fetch_data_q  <= fetch_data_d;
            load_done_q   <= load_done_d;
        end
    end

    // Program storage: deliberately not reset so content survives rst.
    always_ff @(posedge clk) begin
        if (load_beat_s) begin
            mem_q[ptr_q] <= load_data_i;
        end
    end

endmodule
